// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the 32x32 multiply sequencer built on a
// pipelined 16x16 unsigned multiply cell.
package mul_seq_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULXUU = 2'd1,
      MULXSS = 2'd2,
      MULXSU = 2'd3
   } mulOp_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      FIX   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [5:0] PP_SHIFT [4] = '{6'd0, 6'd16, 6'd16, 6'd32};

   // Amount subtracted from the unsigned high word to obtain the signed result
   function automatic logic [31:0] hiCorrection(input mulOp_t op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
      logic [31:0] corr;
      corr = 32'd0;
      case (op)
         MULXSS:  corr = (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
         MULXSU:  corr = a[31] ? b : 32'd0;
         default: corr = 32'd0;
      endcase
      return corr;
   endfunction

endpackage

// File: rtl/mul_seq_tagpipe.sv
// Valid+index shift register that tracks partial products through the
// multiply cell; it advances only while the cell is enabled.
module mul_seq_tagpipe #(
   parameter int DEPTH = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic       flush,
   input  logic       in_valid,
   input  logic [1:0] in_idx,
   output logic       out_valid,
   output logic [1:0] out_idx
);

   logic [DEPTH-1:0]      r_valid;
   logic [DEPTH-1:0][1:0] r_idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         r_idx   <= '0;
      end else if (flush) begin
         r_valid <= '0;
         r_idx   <= '0;
      end else if (en) begin
         r_valid[0] <= in_valid;
         r_idx[0]   <= in_idx;
         for (int i = DEPTH - 1; i > 0; i--) begin
            r_valid[i] <= r_valid[i-1];
            r_idx[i]   <= r_idx[i-1];
         end
      end
   end

   assign out_valid = r_valid[DEPTH-1];
   assign out_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequences a 32x32 multiply as four 16x16 partial products through a shared
// pipelined cell, accumulates them, applies signed correction and responds.
module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int MUL_LAT = 1,
   parameter int W       = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           flush,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [1:0]     req_op,
   input  logic [W-1:0]   req_a,
   input  logic [W-1:0]   req_b,
   output logic           mul_en,
   output logic [15:0]    mul_a,
   output logic [15:0]    mul_b,
   input  logic [31:0]    mul_p,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [W-1:0]   resp_result,
   output logic [2*W-1:0] resp_full
);

   state_t      r_state;
   mulOp_t      r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [1:0]  r_k;
   logic [63:0] r_acc;

   logic        w_tagValid;
   logic [1:0]  w_tagIdx;
   logic [63:0] w_ppShifted;
   logic [31:0] w_hi;

   mul_seq_tagpipe #(.DEPTH(MUL_LAT)) u_tagpipe (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (mul_en),
      .flush    (flush),
      .in_valid (r_state == ISSUE),
      .in_idx   (r_k),
      .out_valid(w_tagValid),
      .out_idx  (w_tagIdx)
   );

   always_comb begin
      w_ppShifted = 64'(mul_p) << PP_SHIFT[w_tagIdx];
      w_hi        = r_acc[63:32] - hiCorrection(r_op, r_a, r_b);
   end

   // All handshake and cell-facing outputs are registered so they change only on edges
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_op        <= MUL;
         r_a         <= '0;
         r_b         <= '0;
         r_k         <= '0;
         r_acc       <= '0;
         req_ready   <= 1'b1;
         mul_en      <= 1'b0;
         mul_a       <= '0;
         mul_b       <= '0;
         resp_valid  <= 1'b0;
         resp_result <= '0;
         resp_full   <= '0;
      end else if (flush) begin
         r_state    <= IDLE;
         r_k        <= '0;
         r_acc      <= '0;
         req_ready  <= 1'b1;
         mul_en     <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         resp_valid <= 1'b0;
      end else begin
         if (mul_en && w_tagValid) begin
            r_acc <= r_acc + w_ppShifted;
         end
         case (r_state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  r_op      <= mulOp_t'(req_op);
                  r_a       <= req_a;
                  r_b       <= req_b;
                  r_k       <= '0;
                  r_acc     <= '0;
                  req_ready <= 1'b0;
                  mul_en    <= 1'b1;
                  mul_a     <= req_a[15:0];
                  mul_b     <= req_b[15:0];
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_k <= r_k + 2'd1;
               // Operands for the next issue slot; after the last slot the cell sees zeros
               case (r_k)
                  2'd0: begin mul_a <= r_a[15:0];  mul_b <= r_b[31:16]; end
                  2'd1: begin mul_a <= r_a[31:16]; mul_b <= r_b[15:0];  end
                  2'd2: begin mul_a <= r_a[31:16]; mul_b <= r_b[31:16]; end
                  default: begin
                     mul_a   <= '0;
                     mul_b   <= '0;
                     r_state <= DRAIN;
                  end
               endcase
            end
            DRAIN: begin
               if (w_tagValid && w_tagIdx == 2'd3) begin
                  mul_en  <= 1'b0;
                  r_state <= FIX;
               end
            end
            FIX: begin
               resp_full   <= {w_hi, r_acc[31:0]};
               resp_result <= (r_op == MUL) ? r_acc[31:0] : w_hi;
               resp_valid  <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_state    <= IDLE;
               req_ready  <= 1'b1;
               mul_en     <= 1'b0;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer that shares one pipelined 16x16 unsigned multiply cell to execute 32x32 multiplies in four partial-product issues.
- Accepts one request at a time over a valid/ready handshake.
- Accumulates the partial products into a 64-bit result, applies a signed correction to the high word, and returns the result over a valid/ready response channel.
- Sits between the execute-stage custom-op decoder and the shared multiplier cell.

Parameters:
- MUL_LAT, 1, register stages in the multiply cell between operand issue and product output; legal range 1..3.
- W, 32, operand width; 16-bit halves are fixed, so only 32 is supported.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- flush  in  1  synchronous abort of the current operation
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  0=MUL (low word), 1=MULXUU, 2=MULXSS, 3=MULXSU (a signed, b unsigned)
- req_a  in  32  operand a
- req_b  in  32  operand b
- mul_en  out  1  clock enable to the multiply cell
- mul_a  out  16  cell operand a
- mul_b  out  16  cell operand b
- mul_p  in  32  cell product, valid MUL_LAT enabled cycles after issue
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts result
- resp_result  out  32  low word for MUL, corrected high word otherwise
- resp_full  out  64  full corrected product

Behaviour:
- Clocking and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - State is IDLE.
  - req_ready=1; resp_valid=0; mul_en=0.
  - mul_a, mul_b, resp_result and resp_full are all 0.
  - Accumulator and in-flight tag pipeline are cleared.
- Request handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on the edge where req_valid & req_ready.
  - Operands and op are latched on accept and held stable internally; req_* may change afterwards.
- State machine:
  - IDLE: on accept, go to ISSUE with issue count k=0 and accumulator acc=0.
  - ISSUE: lasts 4 cycles, k=0..3. mul_en=1.
    - Operand order: (a_lo,b_lo), (a_lo,b_hi), (a_hi,b_lo), (a_hi,b_hi).
    - A tag carrying k enters a MUL_LAT-deep shift register that advances only while mul_en=1.
    - After k=3, go to DRAIN.
  - DRAIN: mul_en=1 with operands 0, until the last tag has emerged (MUL_LAT cycles). Then go to FIX.
  - Accumulation: when a tag emerges, add mul_p into acc.
    - Shift is 0 for k=0, 16 for k=1 and k=2, 32 for k=3.
    - 64-bit add; carries out of bit 63 are discarded.
  - FIX: one cycle, always taken so latency is fixed.
    - MULXSS: hi -= (a[31]?b:0) + (b[31]?a:0).
    - MULXSU: hi -= (a[31]?b:0).
    - MUL and MULXUU: no change.
    - All subtraction is mod 2^32. Then go to DONE.
  - DONE: resp_valid=1; resp_result and resp_full held stable until resp_ready. On handshake, go to IDLE.
- Timing:
  - Accept in cycle T gives resp_valid first high in cycle T+6+MUL_LAT.
  - Back-to-back throughput is one op per 7+MUL_LAT cycles, since the next accept happens in IDLE at the earliest.
- Cell gating: mul_en=0 in IDLE, FIX and DONE. The cell holds its pipeline and its stale product is ignored.
- flush:
  - Valid in any state. Next state is IDLE; tags, accumulator and resp_valid are cleared.
  - A response is never produced for the flushed op.
  - flush together with req_valid in IDLE: flush wins, the request is not accepted, and req_ready stays high.
  - flush in DONE together with resp_ready: the response is dropped, not counted as delivered.
- Reset deassertion mid-operation: resumes cleanly from IDLE; no partial result is emitted.
- An illegal state encoding recovers to IDLE.

Decomposition:
- Shared package mul_seq_pkg holds:
  - the op enum (MUL, MULXUU, MULXSS, MULXSU)
  - the state enum (IDLE, ISSUE, DRAIN, FIX, DONE)
  - partial-product shift constants PP_SHIFT[0..3] = 0,16,16,32
- One natural sub-module, mul_seq_tagpipe: the MUL_LAT-deep valid+index shift register with enable and flush.

Test Plan:
- MULXUU, a=0xFFFFFFFF, b=0xFFFFFFFF, resp_ready=1, MUL_LAT=1 -> resp_valid at accept+7; resp_full=0xFFFFFFFE_00000001; resp_result=0xFFFFFFFE.
- MULXSS, a=0xFFFFFFFF, b=0x00000002 -> resp_full=0xFFFFFFFF_FFFFFFFE; resp_result=0xFFFFFFFF. MUL with the same operands -> resp_result=0xFFFFFFFE.
- MULXSU, a=0x80000000, b=0x80000000 -> resp_result=0xC0000000, resp_full low word=0x00000000. MULXUU with the same operands -> 0x40000000.
- resp_ready low for 5 cycles in DONE -> resp_valid and data stable throughout, req_ready=0, mul_en=0. Handshake -> IDLE; next request accepted in the following cycle.
- flush in the 2nd ISSUE cycle -> IDLE next cycle, resp_valid never asserts. A following MULXUU 0x00010000*0x00010000 -> resp_result=0x00000001, with no contamination from the flushed op.
- reset_n asserted asynchronously mid-DRAIN -> all outputs reach reset values without a clock edge. Rerun with MUL_LAT=3 -> latency is accept+9 and test 1's result repeats.
